seq_compare_unit: RTL and testbench
===================================

// Module: seq_compare_unit
// PURPOSE
//  Parametrised multi-cycle magnitude comparator with registered condition flags. It is the
//  successor to the single-cycle 16-bit compare and adds width/slice parameters, a signed mode,
//  a start/busy/done handshake and early exit. It sits beside the ALU and feeds zf/cf/gt to
//  branch control. The compare walks CHUNK-bit slices MSB-first, one slice per clock.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be a multiple of CHUNK
//  CHUNK   4   slice width compared per cycle; NSLICE = WIDTH/CHUNK (derived, >= 1)
// PORTS
//  Clock        in   1      sole clock, rising edge
//  Reset_n      in   1      asynchronous, active-low reset
//  start        in   1      request compare; sampled only while busy==0
//  a            in   WIDTH  operand A, latched on the accepted start
//  b            in   WIDTH  operand B, latched on the accepted start
//  signed_mode  in   1      1 = two's-complement compare, 0 = unsigned; latched with start
//  busy         out  1      1 while a compare is in progress (state CMP)
//  done         out  1      one-cycle pulse when the flags update
//  zf           out  1      A == B
//  cf           out  1      A < B (under the latched mode)
//  gt           out  1      A > B (under the latched mode)
// BEHAVIOUR
//  - Reset (Reset_n=0, async): state=IDLE, busy=0, done=0, zf=0, cf=0, gt=0, slice index=0.
//    Operand registers are don't-care.
//  - Reset mid-compare aborts the compare immediately. No done pulse; flags are cleared.
//  - States: IDLE, CMP. busy = (state==CMP), combinational from state.
//  - IDLE: if start=1 at an edge, latch a, b and signed_mode, set idx=NSLICE-1, go to CMP.
//    With start=0, stay in IDLE.
//  - start while busy is ignored: no relatch, no effect on the compare in progress.
//  - CMP, each edge: compare slice idx of A and B as unsigned CHUNK-bit values.
//    For the MSB slice in signed mode, invert the top bit of both slices first (bias trick).
//      - slice A > slice B: gt<=1, cf<=0, zf<=0, done<=1, go to IDLE (early exit)
//      - slice A < slice B: cf<=1, gt<=0, zf<=0, done<=1, go to IDLE (early exit)
//      - equal and idx==0: zf<=1, cf<=0, gt<=0, done<=1, go to IDLE
//      - equal and idx>0: idx<=idx-1, stay in CMP
//  - Latency: with the start accepted at edge T0, done is high in the cycle after edge T0+k.
//    k = number of slices examined (1..NSLICE). Full equality always takes k=NSLICE.
//  - done is high for exactly one cycle and is otherwise 0.
//  - zf/cf/gt change only on the done edge and hold until the next done edge or reset.
//    Exactly one of them is 1 after any completed compare.
//  - Back-to-back: in the done cycle the state is IDLE. A start in that cycle is accepted,
//    so a new compare begins with no bubble.
//  - NSLICE==1 degenerates to a fixed 1-cycle compare; the signed bias still applies.
//  - No X propagation: all flag and state registers are reset.
// TESTING (WIDTH=16, CHUNK=4)
//  1. start, a=16'h1234, b=16'h1234, unsigned
//     -> busy for 4 cycles, done after T0+4, zf=1 cf=0 gt=0.
//  2. a=16'h8000, b=16'h0001, unsigned
//     -> done after T0+1 (early exit), gt=1.
//     Same operands with signed_mode=1 -> done after T0+1, cf=1 gt=0.
//  3. a=16'h1235, b=16'h1234, unsigned
//     -> done after T0+4, gt=1.
//     Then a=16'hFFFF, b=16'h0000, signed -> done after T0+1, cf=1 (-1 < 0).
//  4. Pulse start with a=16'h0000, b=16'h0000, then while busy pulse start with a=16'hF000,
//     b=16'h0000 -> second start ignored, result zf=1 after T0+4.
//  5. Start a compare, then drop Reset_n mid-CMP (after T0+2)
//     -> busy=0, zf=cf=gt=0 immediately, no done pulse.
//     After release, a fresh compare completes normally.
//  6. Issue start in the done cycle of a previous compare
//     -> accepted; busy high on the next cycle; flags from the first compare held until the
//        second done.

Source files
------------

// File: rtl/seq_compare_unit.sv
// Multi-cycle magnitude comparator. It walks CHUNK-bit slices MSB-first, one slice per clock,
// and exits early on the first slice that differs. zf/cf/gt are registered and held between compares.
module seq_compare_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             cf,
  output logic             gt
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CMP  = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;

  assign busy = (state == S_CMP);

  // Inverting the sign bit of the top slice maps two's-complement order onto unsigned order.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IW'(i)) begin
        sa = a_q[i*CHUNK +: CHUNK];
        sb = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (sgn_q && (idx == LAST)) begin
      sa[CHUNK-1] = ~sa[CHUNK-1];
      sb[CHUNK-1] = ~sb[CHUNK-1];
    end
  end

  // Operands carry no reset; they are only observed while in CMP.
  always_ff @(posedge Clock) begin
    if ((state == S_IDLE) && start) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= signed_mode;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      idx   <= '0;
      done  <= 1'b0;
      zf    <= 1'b0;
      cf    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= LAST;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          if (sa > sb) begin
            gt    <= 1'b1;
            cf    <= 1'b0;
            zf    <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (sa < sb) begin
            gt    <= 1'b0;
            cf    <= 1'b1;
            zf    <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (idx == '0) begin
            gt    <= 1'b0;
            cf    <= 1'b0;
            zf    <= 1'b1;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_compare_unit.sv
// Scoreboard bench for seq_compare_unit (WIDTH=16, CHUNK=4): stimulus queues expected flags
// and latency; an independent monitor checks each done pulse against the queue head.
module tb_seq_compare_unit;

  typedef struct {
    int   t0;
    int   k;
    logic zf;
    logic cf;
    logic gt;
  } exp_t;

  logic        Clock;
  logic        Reset_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic        zf;
  logic        cf;
  logic        gt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  seq_compare_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy), .done(done), .zf(zf), .cf(cf), .gt(gt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Waits (bounded) for an idle cycle, then drives start for one edge and queues the expectation.
  task automatic do_cmp(input logic [15:0] va, input logic [15:0] vb, input logic sgn,
                        input logic ez, input logic ec, input logic eg, input int k,
                        input logic queue_it);
    exp_t e;
    int   n = 0;
    @(negedge Clock);
    while (busy && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (busy) check("idle_wait_timeout", 32'(busy), 32'd0);
    a = va; b = vb; signed_mode = sgn; start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    e.t0 = cyc; e.k = k; e.zf = ez; e.cf = ec; e.gt = eg;
    if (queue_it) sb_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (Reset_n && done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("flags_zf_cf_gt", {29'd0, zf, cf, gt}, {29'd0, e.zf, e.cf, e.gt});
          check("latency", 32'(cyc - e.t0), 32'(e.k));
          check("busy_in_done_cycle", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    Reset_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_state", {27'd0, busy, done, zf, cf, gt}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // 1: full equality, 4 slices
    do_cmp(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    check("busy_after_start", 32'(busy), 32'd1);
    // 2: early exit, unsigned then signed
    do_cmp(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    do_cmp(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    // 3: LSB slice decides; then -1 < 0 signed
    do_cmp(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1);
    do_cmp(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    // extra signed boundaries
    do_cmp(16'hFFF0, 16'hFFF0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    do_cmp(16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    do_cmp(16'hFF00, 16'hFF01, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b1);

    // 4: start while busy is ignored
    do_cmp(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    @(negedge Clock);
    a = 16'hF000; b = 16'h0000; signed_mode = 1'b1; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;

    // 6: back-to-back; second start lands in the done cycle of the first
    do_cmp(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1);
    do_cmp(16'h5000, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    check("b2b_busy_next_cycle", 32'(busy), 32'd1);
    check("b2b_flags_held", {29'd0, zf, cf, gt}, 32'b010);

    // 5: reset mid-compare (flags are gt=1 beforehand)
    do_cmp(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    #1;
    check("abort_clears", {27'd0, busy, done, zf, cf, gt}, 32'd0);
    repeat (3) @(negedge Clock);
    check("abort_no_done", 32'(done), 32'd0);
    Reset_n = 1'b1;
    do_cmp(16'hA5A5, 16'hA5A4, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
